// File: rtl/vexec_pkg.sv
// ----------------------------------------------------------------------------
// vexec_pkg
// Shared types and constants for the element-serial vector execute stage.
//   vop_t   : 3-bit opcode (ADD, SUB, MUL, AND, OR, XOR, MIN, MAX)
//   state_t : execute-stage FSM states (IDLE, RUN, WB)
//   ELEMS/EW/VW : register-file geometry (16 elements x 16 bits = 256 bits)
// Saturation helpers are only referenced when VEXEC_SAT_EN is defined.
// ----------------------------------------------------------------------------
package vexec_pkg;

    localparam int ELEMS  = 16;
    localparam int EW     = 16;
    localparam int VW     = ELEMS * EW;

    // Intermediate width for saturating arithmetic: wide enough to hold the
    // exact signed product of two 16-bit values plus sign.
    localparam int WIDE_W = 33;

    localparam logic signed [WIDE_W-1:0] SAT_MAX = 33'sd32767;
    localparam logic signed [WIDE_W-1:0] SAT_MIN = -33'sd32768;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_MIN = 3'd6,
        OP_MAX = 3'd7
    } vop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

    function automatic logic is_ovf(input logic signed [WIDE_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    function automatic logic [EW-1:0] sat_clamp(input logic signed [WIDE_W-1:0] v);
        if (v > SAT_MAX) begin
            return 16'h7FFF;
        end else if (v < SAT_MIN) begin
            return 16'h8000;
        end
        return v[EW-1:0];
    endfunction

endpackage

// File: rtl/vexec_lane.sv
// ----------------------------------------------------------------------------
// vexec_lane
// Combinational single-element ALU.
//   op  : vop_t opcode
//   a,b : 16-bit source elements
//   y   : 16-bit result
//   sat : (only with VEXEC_SAT_EN) result was clamped to 0x7FFF / 0x8000
// Build option VEXEC_SAT_EN: ADD/SUB/MUL saturate to signed 16-bit limits;
// otherwise they wrap modulo 2^16 (MUL keeps the low 16 product bits).
// ----------------------------------------------------------------------------
module vexec_lane
    import vexec_pkg::*;
(
    input  vop_t          op,
    input  logic [EW-1:0] a,
    input  logic [EW-1:0] b,
`ifdef VEXEC_SAT_EN
    output logic          sat,
`endif
    output logic [EW-1:0] y
);

    logic lt_signed;
    assign lt_signed = $signed(a) < $signed(b);

`ifdef VEXEC_SAT_EN
    logic signed [WIDE_W-1:0] a_w;
    logic signed [WIDE_W-1:0] b_w;
    logic signed [WIDE_W-1:0] sum_w;
    logic signed [WIDE_W-1:0] dif_w;
    logic signed [WIDE_W-1:0] prod_w;

    assign a_w    = {{(WIDE_W-EW){a[EW-1]}}, a};
    assign b_w    = {{(WIDE_W-EW){b[EW-1]}}, b};
    assign sum_w  = a_w + b_w;
    assign dif_w  = a_w - b_w;
    assign prod_w = a_w * b_w;
`endif

    always_comb begin
        y = '0;
`ifdef VEXEC_SAT_EN
        sat = 1'b0;
`endif
        case (op)
`ifdef VEXEC_SAT_EN
            OP_ADD: begin
                y   = sat_clamp(sum_w);
                sat = is_ovf(sum_w);
            end
            OP_SUB: begin
                y   = sat_clamp(dif_w);
                sat = is_ovf(dif_w);
            end
            OP_MUL: begin
                y   = sat_clamp(prod_w);
                sat = is_ovf(prod_w);
            end
`else
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            // Low 16 bits of a two's-complement product do not depend on
            // signedness, so a plain 16-bit multiply is exact here.
            OP_MUL: y = a * b;
`endif
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_MIN: y = lt_signed ? a : b;
            OP_MAX: y = lt_signed ? b : a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vector_exec_unit.sv
// ----------------------------------------------------------------------------
// vector_exec_unit
// Element-serial vector execute stage feeding the 16x16x16-bit register file
// write port. Processes LANES elements per cycle and emits one write-back.
//   clk, rst_n         : clock, asynchronous active-low reset
//   inValid/inReady    : op offer / accept
//   inOp, inA, inB     : opcode and 256-bit source vectors
//   inLen, inDest      : active element count minus 1, destination register
//   busy, busyDest     : op in flight (RUN or WB) and its destination
//   wEn/wAddr/wLen/wData : single-cycle write-back to the register file
//   satFlag            : (only with VEXEC_SAT_EN) an active element saturated
//   dbg_state          : current FSM state (state_t encoding)
// Build option VEXEC_SAT_EN: saturating ADD/SUB/MUL and the satFlag output.
//
// Handshake: an op transfers on a rising edge where inValid & inReady are
// both high. inReady is high only in IDLE and does not depend on inValid;
// the source holds inValid and operands stable until the transfer.
// ----------------------------------------------------------------------------
module vector_exec_unit
    import vexec_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inValid,
    output logic          inReady,
    input  logic [2:0]    inOp,
    input  logic [VW-1:0] inA,
    input  logic [VW-1:0] inB,
    input  logic [3:0]    inLen,
    input  logic [3:0]    inDest,
    output logic          busy,
    output logic [3:0]    busyDest,
    output logic          wEn,
    output logic [3:0]    wAddr,
    output logic [3:0]    wLen,
    output logic [VW-1:0] wData,
`ifdef VEXEC_SAT_EN
    output logic          satFlag,
`endif
    output logic [1:0]    dbg_state
);

    localparam int LSH = $clog2(LANES);

    state_t        state_q, state_d;
    vop_t          op_q, op_d;
    logic [VW-1:0] a_q, a_d;
    logic [VW-1:0] b_q, b_d;
    logic [3:0]    len_q, len_d;
    logic [3:0]    dest_q, dest_d;
    logic [3:0]    grp_q, grp_d;
    logic [VW-1:0] res_q, res_d;
    logic          wen_q, wen_d;
    logic [3:0]    waddr_q, waddr_d;
    logic [3:0]    wlen_q, wlen_d;
    logic [VW-1:0] wdata_q, wdata_d;
`ifdef VEXEC_SAT_EN
    logic          sat_acc_q, sat_acc_d;
    logic          sat_flag_q, sat_flag_d;
`endif

    logic [3:0]    last_grp;
    logic [3:0]    lane_idx [LANES];
    logic [EW-1:0] lane_y   [LANES];
`ifdef VEXEC_SAT_EN
    logic          lane_sat [LANES];
`endif

    // Group containing element len_q; RUN ends after processing it.
    assign last_grp = len_q >> LSH;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        // Element handled by lane l in the current group: grp*LANES + l.
        assign lane_idx[l] = 4'((int'(grp_q) << LSH) + l);

        vexec_lane u_lane (
            .op  (op_q),
            .a   (a_q[lane_idx[l]*EW +: EW]),
            .b   (b_q[lane_idx[l]*EW +: EW]),
`ifdef VEXEC_SAT_EN
            .sat (lane_sat[l]),
`endif
            .y   (lane_y[l])
        );
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        len_d   = len_q;
        dest_d  = dest_q;
        grp_d   = grp_q;
        res_d   = res_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wlen_d  = wlen_q;
        wdata_d = wdata_q;
`ifdef VEXEC_SAT_EN
        sat_acc_d  = sat_acc_q;
        sat_flag_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (inValid) begin
                    op_d    = vop_t'(inOp);
                    a_d     = inA;
                    b_d     = inB;
                    len_d   = inLen;
                    dest_d  = inDest;
                    grp_d   = '0;
                    res_d   = '0;
`ifdef VEXEC_SAT_EN
                    sat_acc_d = 1'b0;
`endif
                    state_d = RUN;
                end
            end

            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    // Elements past len_q are forced to zero even inside the
                    // final group, and never contribute to saturation.
                    if (lane_idx[l] <= len_q) begin
                        res_d[lane_idx[l]*EW +: EW] = lane_y[l];
`ifdef VEXEC_SAT_EN
                        sat_acc_d = sat_acc_d | lane_sat[l];
`endif
                    end else begin
                        res_d[lane_idx[l]*EW +: EW] = '0;
                    end
                end
                grp_d = grp_q + 4'd1;
                if (grp_q == last_grp) begin
                    // Load the write-back registers with the final result so
                    // they hold steady after WB until the next op completes.
                    state_d = WB;
                    wen_d   = 1'b1;
                    waddr_d = dest_q;
                    wlen_d  = len_q;
                    wdata_d = res_d;
`ifdef VEXEC_SAT_EN
                    sat_flag_d = sat_acc_d;
`endif
                end
            end

            WB: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            len_q   <= '0;
            dest_q  <= '0;
            grp_q   <= '0;
            res_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wlen_q  <= '0;
            wdata_q <= '0;
`ifdef VEXEC_SAT_EN
            sat_acc_q  <= 1'b0;
            sat_flag_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            len_q   <= len_d;
            dest_q  <= dest_d;
            grp_q   <= grp_d;
            res_q   <= res_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wlen_q  <= wlen_d;
            wdata_q <= wdata_d;
`ifdef VEXEC_SAT_EN
            sat_acc_q  <= sat_acc_d;
            sat_flag_q <= sat_flag_d;
`endif
        end
    end

    assign inReady   = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign busyDest  = dest_q;
    assign wEn       = wen_q;
    assign wAddr     = waddr_q;
    assign wLen      = wlen_q;
    assign wData     = wdata_q;
    assign dbg_state = state_q;
`ifdef VEXEC_SAT_EN
    assign satFlag   = sat_flag_q;
`endif

endmodule

// File: tb/tb_vector_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_vector_exec_unit
// Directed-vector bench for vector_exec_unit (LANES=4). The driver pushes the
// hand-derived write-back (data, addr, len, sat, expected wEn edge) into
// exp_q at each accept; a negedge monitor pops and compares on every wEn.
// Covers both builds (VEXEC_SAT_EN defined or not).
// ----------------------------------------------------------------------------
module tb_vector_exec_unit;
    import vexec_pkg::*;

    localparam int LANES = 4;
    localparam int EXP_W = 32 + 1 + 4 + 4 + 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // ---------------- DUT ----------------
    logic         inValid;
    logic         inReady;
    logic [2:0]   inOp;
    logic [255:0] inA;
    logic [255:0] inB;
    logic [3:0]   inLen;
    logic [3:0]   inDest;
    logic         busy;
    logic [3:0]   busyDest;
    logic         wEn;
    logic [3:0]   wAddr;
    logic [3:0]   wLen;
    logic [255:0] wData;
    logic [1:0]   dbg_state;
`ifdef VEXEC_SAT_EN
    logic         satFlag;
`endif

    vector_exec_unit #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inValid   (inValid),
        .inReady   (inReady),
        .inOp      (inOp),
        .inA       (inA),
        .inB       (inB),
        .inLen     (inLen),
        .inDest    (inDest),
        .busy      (busy),
        .busyDest  (busyDest),
        .wEn       (wEn),
        .wAddr     (wAddr),
        .wLen      (wLen),
        .wData     (wData),
`ifdef VEXEC_SAT_EN
        .satFlag   (satFlag),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_e;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wen: got wEn=1 at edge %0d expected no write-back", edge_n);
            end else begin
                mon_e = exp_q.pop_front();
                check("wdata",    wData,         mon_e[255:0]);
                check("waddr",    256'(wAddr),   256'(mon_e[259:256]));
                check("wlen",     256'(wLen),    256'(mon_e[263:260]));
                check("wen_edge", 256'(edge_n),  256'(mon_e[296:265]));
`ifdef VEXEC_SAT_EN
                check("sat_flag", 256'(satFlag), 256'(mon_e[264]));
`endif
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [255:0] splat(input logic [15:0] v);
        logic [255:0] r;
        for (int i = 0; i < 16; i++) r[16*i +: 16] = v;
        return r;
    endfunction

    // Zero elements beyond len, as the write-back must.
    function automatic logic [255:0] keep(input logic [255:0] v, input logic [3:0] len);
        logic [255:0] r;
        r = v;
        for (int i = 0; i < 16; i++) if (i > int'(len)) r[16*i +: 16] = 16'h0000;
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic send_op(input logic [2:0] op, input logic [255:0] a, input logic [255:0] b,
                           input logic [3:0] len, input logic [3:0] dest,
                           input logic [255:0] exp_data, input logic exp_sat,
                           input bit expect_wb, output int acc);
        int waited;
        int n;
        @(negedge clk);
        inValid = 1'b1;
        inOp    = op;
        inA     = a;
        inB     = b;
        inLen   = len;
        inDest  = dest;
        waited  = 0;
        while (inReady !== 1'b1 && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        acc = edge_n + 1;
        if (inReady !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got inReady=%b after %0d cycles expected 1", inReady, waited);
            inValid = 1'b0;
            return;
        end
        n = int'(len) / LANES + 1;
        if (expect_wb) exp_q.push_back({32'(acc + n), exp_sat, len, dest, exp_data});
        @(posedge clk);
        #1;
        // Scramble inputs after accept: the captured op must be unaffected.
        inValid = 1'b0;
        inA     = {8{$urandom}};
        inB     = {8{$urandom}};
        inOp    = 3'($urandom_range(0, 7));
        inLen   = 4'($urandom_range(0, 15));
        inDest  = 4'($urandom_range(0, 15));
        @(negedge clk);
        check("busy_in_run",     256'(busy),     256'(1));
        check("busydest_in_run", 256'(busyDest), 256'(dest));
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 60) begin
            waited++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending write-backs expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    logic [255:0] va, vb, ve;
    int acc1, acc2, acc3;

    initial begin
        inValid = 1'b0;
        inOp    = '0;
        inA     = '0;
        inB     = '0;
        inLen   = '0;
        inDest  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_inready",  256'(inReady),   256'(1));
        check("rst_busy",     256'(busy),      256'(0));
        check("rst_wen",      256'(wEn),       256'(0));
        check("rst_wdata",    wData,           256'(0));
        check("rst_waddr",    256'(wAddr),     256'(0));
        check("rst_wlen",     256'(wLen),      256'(0));
        check("rst_busydest", 256'(busyDest),  256'(0));
        check("rst_state",    256'(dbg_state), 256'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // ADD len=15: A[i]=i, B[i]=0x0100 -> 0x0100+i, N=4
        for (int i = 0; i < 16; i++) begin
            va[16*i +: 16] = 16'(i);
            ve[16*i +: 16] = 16'h0100 + 16'(i);
        end
        send_op(3'd0, va, splat(16'h0100), 4'd15, 4'd3, ve, 1'b0, 1'b1, acc1);
        drain();

        // SUB len=2: 5-7 = 0xFFFE in elements 0..2, rest zero, N=1
        send_op(3'd1, splat(16'h0005), splat(16'h0007), 4'd2, 4'd5,
                keep(splat(16'hFFFE), 4'd2), 1'b0, 1'b1, acc1);
        drain();

        // MUL 0x7FFF*2, len=0 (inactive lanes also overflow but are ignored)
`ifdef VEXEC_SAT_EN
        send_op(3'd2, splat(16'h7FFF), splat(16'h0002), 4'd0, 4'd7,
                256'h7FFF, 1'b1, 1'b1, acc1);
`else
        send_op(3'd2, splat(16'h7FFF), splat(16'h0002), 4'd0, 4'd7,
                256'hFFFE, 1'b0, 1'b1, acc1);
`endif
        drain();

        // ADD len=1: e0 = 0x7FFF+1, e1 = 1+1
        va = splat(16'h7FFF);
        va[31:16] = 16'h0001;
`ifdef VEXEC_SAT_EN
        send_op(3'd0, va, splat(16'h0001), 4'd1, 4'd9,
                {224'h0, 16'h0002, 16'h7FFF}, 1'b1, 1'b1, acc1);
`else
        send_op(3'd0, va, splat(16'h0001), 4'd1, 4'd9,
                {224'h0, 16'h0002, 16'h8000}, 1'b0, 1'b1, acc1);
`endif
        drain();

        // ADD len=0: active 1+1, inactive lanes would saturate but must not flag
        va = splat(16'h7FFF);
        va[15:0] = 16'h0001;
        vb = va;
        send_op(3'd0, va, vb, 4'd0, 4'd1, 256'h0002, 1'b0, 1'b1, acc1);
        drain();

        // Back-to-back offers held through RUN/WB: AND len=7, OR len=3, XOR len=4
        for (int i = 0; i < 16; i++) begin
            va[16*i +: 16] = 16'hFF00 | 16'(i);
            ve[16*i +: 16] = 16'h0F00 + 16'(i);
        end
        send_op(3'd3, va, splat(16'h0F0F), 4'd7, 4'd2, keep(ve, 4'd7), 1'b0, 1'b1, acc1);
        for (int i = 0; i < 16; i++) begin
            vb[16*i +: 16] = 16'(i);
            ve[16*i +: 16] = 16'h1000 | 16'(i);
        end
        send_op(3'd4, splat(16'h1000), vb, 4'd3, 4'd4, keep(ve, 4'd3), 1'b0, 1'b1, acc2);
        check("b2b_accept_1", 256'(acc2), 256'(acc1 + 2 + 2));
        send_op(3'd5, splat(16'hAAAA), splat(16'h00FF), 4'd4, 4'd6,
                keep(splat(16'hAA55), 4'd4), 1'b0, 1'b1, acc3);
        check("b2b_accept_2", 256'(acc3), 256'(acc2 + 1 + 2));
        drain();

        // Signed MIN / MAX, and a negative MUL that stays in range
        send_op(3'd6, splat(16'h8000), splat(16'h0001), 4'd0, 4'd8, 256'h8000, 1'b0, 1'b1, acc1);
        drain();
        send_op(3'd7, splat(16'h8000), splat(16'h0001), 4'd0, 4'd10, 256'h0001, 1'b0, 1'b1, acc1);
        drain();
        send_op(3'd2, splat(16'hFFFF), splat(16'h0003), 4'd0, 4'd11, 256'hFFFD, 1'b0, 1'b1, acc1);
        drain();

        // Reset mid-RUN: op dropped, no write-back, back to IDLE
        send_op(3'd0, splat(16'h1111), splat(16'h2222), 4'd15, 4'd12, '0, 1'b0, 1'b0, acc1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_inready", 256'(inReady),   256'(1));
        check("abort_busy",    256'(busy),      256'(0));
        check("abort_state",   256'(dbg_state), 256'(IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Recovery: SUB len=15, 0x8000-1 wraps to 0x7FFF or saturates to 0x8000
`ifdef VEXEC_SAT_EN
        send_op(3'd1, splat(16'h8000), splat(16'h0001), 4'd15, 4'd13,
                splat(16'h8000), 1'b1, 1'b1, acc1);
`else
        send_op(3'd1, splat(16'h8000), splat(16'h0001), 4'd15, 4'd13,
                splat(16'h7FFF), 1'b0, 1'b1, acc1);
`endif
        drain();
        repeat (4) @(negedge clk);
        check("final_wen_idle", 256'(wEn), 256'(0));
        check("final_state",    256'(dbg_state), 256'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units expected $finish");
        $fatal(1);
    end

endmodule
